// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Tracks the destination registers in flight in EX/MEM/WB and derives
// stall, flush, EX forwarding selects and the ID write-back bypass.
module pipe_hazard_ctrl #(
   parameter int EN_FWD = 1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [4:0]       id_rw,
   input  logic             id_regwr,
   input  logic             id_memtoreg,
   input  logic             ex_br_taken,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             id_byp_a,
   output logic             id_byp_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic             FWD_ON  = (EN_FWD != 0);
   localparam logic [1:0]       SEL_REG = 2'b00;
   localparam logic [1:0]       SEL_MEM = 2'b01;
   localparam logic [1:0]       SEL_WB  = 2'b10;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Scoreboard entries. The load flag only matters while the producer is
   // in EX (load-use), so MEM and WB do not carry it.
   logic       ex_v_reg, ex_regwr_reg, ex_ld_reg;
   logic [4:0] ex_rw_reg;
   logic       mem_v_reg, mem_regwr_reg;
   logic [4:0] mem_rw_reg;
   logic       wb_v_reg, wb_regwr_reg;
   logic [4:0] wb_rw_reg;

   logic [1:0]       fwd_a_reg, fwd_b_reg, fwd_a_next, fwd_b_next;
   logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

   logic use_a, use_b;
   logic ex_wa, ex_wb, mem_wa, mem_wb, wb_wa, wb_wb;
   logic raw_ex, raw_mem, raw_wb, stall_raw;
   logic stall, flush;

   // Register 0 is hard-wired, so a write to it never creates a dependency.
   function automatic logic writes(input logic v, input logic regwr,
                                   input logic [4:0] rw, input logic [4:0] r);
      return v & regwr & (rw == r) & (r != 5'd0);
   endfunction

   // Hazard detection against the scoreboard; reset and flush mask the stall.
   always_comb begin
      use_a     = id_valid & id_use_rs;
      use_b     = id_valid & id_use_rt;
      ex_wa     = writes(ex_v_reg,  ex_regwr_reg,  ex_rw_reg,  id_rs);
      ex_wb     = writes(ex_v_reg,  ex_regwr_reg,  ex_rw_reg,  id_rt);
      mem_wa    = writes(mem_v_reg, mem_regwr_reg, mem_rw_reg, id_rs);
      mem_wb    = writes(mem_v_reg, mem_regwr_reg, mem_rw_reg, id_rt);
      wb_wa     = writes(wb_v_reg,  wb_regwr_reg,  wb_rw_reg,  id_rs);
      wb_wb     = writes(wb_v_reg,  wb_regwr_reg,  wb_rw_reg,  id_rt);
      raw_ex    = (ex_wa  & use_a) | (ex_wb  & use_b);
      raw_mem   = (mem_wa & use_a) | (mem_wb & use_b);
      raw_wb    = (wb_wa  & use_a) | (wb_wb  & use_b);
      // With forwarding only a load still in EX cannot be served in time;
      // without it every in-flight producer (WB included, since the register
      // file has no internal bypass) blocks the consumer.
      stall_raw = FWD_ON ? (ex_ld_reg & raw_ex) : (raw_ex | raw_mem | raw_wb);
      flush     = ex_br_taken & ~rst;
      stall     = stall_raw & ~flush & ~rst;
   end

   assign pc_en      = ~stall;
   assign ifid_en    = ~stall;
   assign ifid_flush = flush;
   assign idex_flush = flush | stall;
   assign id_byp_a   = FWD_ON & wb_wa & id_use_rs & ~rst;
   assign id_byp_b   = FWD_ON & wb_wb & id_use_rt & ~rst;
   assign fwd_a      = fwd_a_reg;
   assign fwd_b      = fwd_b_reg;
   assign stall_cnt  = stall_cnt_reg;
   assign flush_cnt  = flush_cnt_reg;

   // Forward selects for the instruction about to enter EX; nearest producer wins.
   always_comb begin
      fwd_a_next = SEL_REG;
      fwd_b_next = SEL_REG;
      if (FWD_ON && id_valid && !stall && !flush) begin
         if (ex_wa)       fwd_a_next = SEL_MEM;
         else if (mem_wa) fwd_a_next = SEL_WB;
         if (ex_wb)       fwd_b_next = SEL_MEM;
         else if (mem_wb) fwd_b_next = SEL_WB;
      end
   end

   // Scoreboard shift, registered forward selects and saturating counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_v_reg      <= 1'b0;
         ex_regwr_reg  <= 1'b0;
         ex_ld_reg     <= 1'b0;
         ex_rw_reg     <= 5'd0;
         mem_v_reg     <= 1'b0;
         mem_regwr_reg <= 1'b0;
         mem_rw_reg    <= 5'd0;
         wb_v_reg      <= 1'b0;
         wb_regwr_reg  <= 1'b0;
         wb_rw_reg     <= 5'd0;
         fwd_a_reg     <= SEL_REG;
         fwd_b_reg     <= SEL_REG;
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         wb_v_reg      <= mem_v_reg;
         wb_regwr_reg  <= mem_regwr_reg;
         wb_rw_reg     <= mem_rw_reg;
         mem_v_reg     <= ex_v_reg;
         mem_regwr_reg <= ex_regwr_reg;
         mem_rw_reg    <= ex_rw_reg;
         ex_v_reg      <= id_valid & ~stall & ~flush;
         ex_regwr_reg  <= id_regwr;
         ex_ld_reg     <= id_memtoreg;
         ex_rw_reg     <= id_rw;
         fwd_a_reg     <= fwd_a_next;
         fwd_b_reg     <= fwd_b_next;
         if (stall && stall_cnt_reg != CNT_MAX)
            stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
         if (flush && flush_cnt_reg != CNT_MAX)
            flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a forwarding instance (CNT_W=16) and a
// stall-only instance (CNT_W=2) share one stimulus stream; expected values are
// queued per cycle and compared against the selected instance mid-cycle.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_use_rs, id_use_rt, id_regwr, id_memtoreg, ex_br_taken;
   logic [4:0] id_rs, id_rt, id_rw;

   logic        pc_en0, ifid_en0, ifid_flush0, idex_flush0, id_byp_a0, id_byp_b0;
   logic [1:0]  fwd_a0, fwd_b0;
   logic [15:0] stall_cnt0, flush_cnt0;
   logic        pc_en1, ifid_en1, ifid_flush1, idex_flush1, id_byp_a1, id_byp_b1;
   logic [1:0]  fwd_a1, fwd_b1;
   logic [1:0]  stall_cnt1, flush_cnt1;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.EN_FWD(1), .CNT_W(16)) u_fwd (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rw(id_rw),
      .id_regwr(id_regwr), .id_memtoreg(id_memtoreg), .ex_br_taken(ex_br_taken),
      .pc_en(pc_en0), .ifid_en(ifid_en0), .ifid_flush(ifid_flush0),
      .idex_flush(idex_flush0), .fwd_a(fwd_a0), .fwd_b(fwd_b0),
      .id_byp_a(id_byp_a0), .id_byp_b(id_byp_b0),
      .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
   );

   pipe_hazard_ctrl #(.EN_FWD(0), .CNT_W(2)) u_nofwd (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rw(id_rw),
      .id_regwr(id_regwr), .id_memtoreg(id_memtoreg), .ex_br_taken(ex_br_taken),
      .pc_en(pc_en1), .ifid_en(ifid_en1), .ifid_flush(ifid_flush1),
      .idex_flush(idex_flush1), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
      .id_byp_a(id_byp_a1), .id_byp_b(id_byp_b1),
      .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
   );

   localparam int S_PC = 0, S_IFEN = 1, S_IFFL = 2, S_IDFL = 3, S_FA = 4;
   localparam int S_FB = 5, S_BA = 6, S_BB = 7, S_SC = 8, S_FC = 9;

   typedef struct {
      string       tag;
      int          dut;
      int          sig;
      logic [15:0] want;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   cur_dut = 0;

   function automatic logic [15:0] obs(input int d, input int s);
      logic [15:0] r;
      r = '0;
      if (d == 0) begin
         case (s)
            S_PC:    r = {15'd0, pc_en0};
            S_IFEN:  r = {15'd0, ifid_en0};
            S_IFFL:  r = {15'd0, ifid_flush0};
            S_IDFL:  r = {15'd0, idex_flush0};
            S_FA:    r = {14'd0, fwd_a0};
            S_FB:    r = {14'd0, fwd_b0};
            S_BA:    r = {15'd0, id_byp_a0};
            S_BB:    r = {15'd0, id_byp_b0};
            S_SC:    r = stall_cnt0;
            default: r = flush_cnt0;
         endcase
      end else begin
         case (s)
            S_PC:    r = {15'd0, pc_en1};
            S_IFEN:  r = {15'd0, ifid_en1};
            S_IFFL:  r = {15'd0, ifid_flush1};
            S_IDFL:  r = {15'd0, idex_flush1};
            S_FA:    r = {14'd0, fwd_a1};
            S_FB:    r = {14'd0, fwd_b1};
            S_BA:    r = {15'd0, id_byp_a1};
            S_BB:    r = {15'd0, id_byp_b1};
            S_SC:    r = {14'd0, stall_cnt1};
            default: r = {14'd0, flush_cnt1};
         endcase
      end
      return r;
   endfunction

   task automatic push(input string tag, input int sig, input logic [15:0] want);
      exp_t e;
      e.tag  = tag;
      e.dut  = cur_dut;
      e.sig  = sig;
      e.want = want;
      sb.push_back(e);
   endtask

   // Compare queued expectations mid-cycle, then advance past the next edge.
   task automatic tick();
      exp_t        e;
      logic [15:0] o;
      int          n;
      n = 0;
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs(e.dut, e.sig);
         checks++;
         n++;
         assert (o === e.want) else begin
            errors++;
            $error("FAIL %s cycle %0d dut %0d observed=%0h expected=%0h",
                   e.tag, cyc, e.dut, o, e.want);
         end
      end
      $display("cycle %0d dut %0d rst=%0b id_valid=%0b rs=%0d rt=%0d rw=%0d br=%0b : %0d checks",
               cyc, cur_dut, rst, id_valid, id_rs, id_rt, id_rw, ex_br_taken, n);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic i_nop();
      id_valid = 1'b1; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
      id_rw = 5'd0; id_regwr = 1'b0; id_memtoreg = 1'b0;
   endtask

   task automatic i_alu(input logic [4:0] rw, input logic [4:0] rs, input logic [4:0] rt);
      id_valid = 1'b1; id_rs = rs; id_rt = rt; id_use_rs = 1'b1; id_use_rt = 1'b1;
      id_rw = rw; id_regwr = 1'b1; id_memtoreg = 1'b0;
   endtask

   task automatic i_lw(input logic [4:0] rw, input logic [4:0] rs);
      id_valid = 1'b1; id_rs = rs; id_rt = rw; id_use_rs = 1'b1; id_use_rt = 1'b0;
      id_rw = rw; id_regwr = 1'b1; id_memtoreg = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ex_br_taken = 1'b0;
      i_nop();

      // ---------------- forwarding instance ----------------
      cur_dut = 0;
      ex_br_taken = 1'b1; i_alu(5'd3, 5'd1, 5'd2);
      push("rst_pc_en", S_PC, 16'd1); push("rst_ifid_en", S_IFEN, 16'd1);
      push("rst_ifid_flush", S_IFFL, 16'd0); push("rst_idex_flush", S_IDFL, 16'd0);
      push("rst_byp_a", S_BA, 16'd0);
      tick();
      rst = 1'b0; ex_br_taken = 1'b0; i_nop();
      push("rst_fwd_a", S_FA, 16'd0); push("rst_fwd_b", S_FB, 16'd0);
      push("rst_stall_cnt", S_SC, 16'd0); push("rst_flush_cnt", S_FC, 16'd0);
      tick();
      // chain: add $3=$1,$2 ; sub $4=$3,$5
      i_alu(5'd3, 5'd1, 5'd2); push("chain_add_pc", S_PC, 16'd1); tick();
      i_alu(5'd4, 5'd3, 5'd5); push("chain_sub_pc", S_PC, 16'd1);
      push("chain_sub_idex", S_IDFL, 16'd0); tick();
      i_nop(); push("chain_fwd_a", S_FA, 16'd1); push("chain_fwd_b", S_FB, 16'd0);
      push("chain_stall_cnt", S_SC, 16'd0); tick();
      // distance 2: add $3 ; nop ; or $6=$3,$3
      i_alu(5'd3, 5'd1, 5'd2); push("d2_prev_fwd_a", S_FA, 16'd0); tick();
      i_nop(); push("d2_nop_pc", S_PC, 16'd1); tick();
      i_alu(5'd6, 5'd3, 5'd3); push("d2_or_pc", S_PC, 16'd1); tick();
      i_nop(); push("d2_fwd_a", S_FA, 16'd2); push("d2_fwd_b", S_FB, 16'd2); tick();
      // load-use: lw $8 ; add $9=$8,$1
      i_lw(5'd8, 5'd1); push("lu_lw_pc", S_PC, 16'd1); tick();
      i_alu(5'd9, 5'd8, 5'd1);
      push("lu_stall_pc", S_PC, 16'd0); push("lu_stall_ifen", S_IFEN, 16'd0);
      push("lu_stall_idex", S_IDFL, 16'd1); push("lu_stall_ifid_flush", S_IFFL, 16'd0);
      tick();
      i_alu(5'd9, 5'd8, 5'd1);
      push("lu_resume_pc", S_PC, 16'd1); push("lu_resume_ifen", S_IFEN, 16'd1);
      push("lu_resume_idex", S_IDFL, 16'd0); push("lu_stall_cnt", S_SC, 16'd1);
      tick();
      i_nop(); push("lu_fwd_a", S_FA, 16'd2); push("lu_fwd_b", S_FB, 16'd0);
      push("lu_stall_cnt_hold", S_SC, 16'd1); tick();
      // distance 3: lw $8 ; nop ; nop ; add $9=$8,$8
      i_lw(5'd8, 5'd1); tick();
      i_nop(); push("d3_nop1_pc", S_PC, 16'd1); tick();
      i_nop(); tick();
      i_alu(5'd9, 5'd8, 5'd8); push("d3_byp_a", S_BA, 16'd1); push("d3_byp_b", S_BB, 16'd1);
      push("d3_pc", S_PC, 16'd1); tick();
      i_nop(); push("d3_fwd_a", S_FA, 16'd0); push("d3_fwd_b", S_FB, 16'd0);
      push("d3_byp_a_off", S_BA, 16'd0); tick();
      // taken branch coinciding with a load-use condition
      i_lw(5'd8, 5'd1); tick();
      i_alu(5'd9, 5'd8, 5'd1); ex_br_taken = 1'b1;
      push("br_ifid_flush", S_IFFL, 16'd1); push("br_idex_flush", S_IDFL, 16'd1);
      push("br_pc_en", S_PC, 16'd1); push("br_ifid_en", S_IFEN, 16'd1);
      tick();
      ex_br_taken = 1'b0; i_nop();
      push("br_stall_cnt", S_SC, 16'd1); push("br_flush_cnt", S_FC, 16'd1);
      push("br_fwd_a", S_FA, 16'd0); push("br_ifid_flush_off", S_IFFL, 16'd0);
      tick();
      // writes to $0: lw $0 ; add $9=$0,$0 ; nop ; sub $9=$0,$0
      i_lw(5'd0, 5'd1); tick();
      i_alu(5'd9, 5'd0, 5'd0); push("r0_pc", S_PC, 16'd1); push("r0_idex", S_IDFL, 16'd0); tick();
      i_nop(); push("r0_fwd_a", S_FA, 16'd0); push("r0_fwd_b", S_FB, 16'd0); tick();
      i_alu(5'd9, 5'd0, 5'd0); push("r0_byp_a", S_BA, 16'd0); push("r0_byp_b", S_BB, 16'd0); tick();

      // ---------------- stall-only instance, CNT_W=2 ----------------
      cur_dut = 1;
      rst = 1'b1; i_nop(); push("nf_rst_pc", S_PC, 16'd1); tick();
      rst = 1'b0;
      for (int rep = 0; rep < 2; rep++) begin
         i_alu(5'd3, 5'd1, 5'd2); push("nf_add_pc", S_PC, 16'd1); tick();
         for (int k = 0; k < 3; k++) begin
            i_alu(5'd4, 5'd3, 5'd5);
            push("nf_stall_pc", S_PC, 16'd0); push("nf_stall_idex", S_IDFL, 16'd1);
            push("nf_stall_fwd_a", S_FA, 16'd0);
            push("nf_stall_cnt", S_SC, (rep == 0) ? 16'(k) : 16'd3);
            tick();
         end
         i_alu(5'd4, 5'd3, 5'd5);
         push("nf_release_pc", S_PC, 16'd1); push("nf_release_cnt", S_SC, 16'd3); tick();
         i_nop(); push("nf_fwd_a", S_FA, 16'd0); push("nf_fwd_b", S_FB, 16'd0);
         push("nf_sat_cnt", S_SC, 16'd3); tick();
      end
      // reset in the middle of a stall
      i_alu(5'd3, 5'd1, 5'd2); tick();
      i_alu(5'd4, 5'd3, 5'd5); push("nf_pre_rst_pc", S_PC, 16'd0); tick();
      rst = 1'b1;
      push("nf_in_rst_pc", S_PC, 16'd1); push("nf_in_rst_ifen", S_IFEN, 16'd1);
      push("nf_in_rst_idex", S_IDFL, 16'd0); push("nf_in_rst_cnt", S_SC, 16'd3);
      tick();
      rst = 1'b0;
      push("nf_post_rst_pc", S_PC, 16'd1); push("nf_post_rst_idex", S_IDFL, 16'd0);
      push("nf_post_rst_stall_cnt", S_SC, 16'd0); push("nf_post_rst_flush_cnt", S_FC, 16'd0);
      tick();
      i_nop(); push("nf_post_rst_fwd_a", S_FA, 16'd0); push("nf_post_rst_cnt2", S_SC, 16'd0); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage IF/ID/EX/MEM/WB datapath.
- Keeps its own scoreboard of in-flight destination registers for the EX, MEM and WB stages.
- Generates PC/IF-ID enables, flushes/bubbles, EX-stage forwarding selects and ID-stage write-back bypass.
- Counts stall and flush cycles for performance debug.

Parameters:
- EN_FWD, 1, 1 = forwarding and bypass enabled; 0 = stall on every RAW hazard until the producer retires.
- CNT_W, 16, width of the saturating stall and flush counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  5  source register A of the ID instruction.
- id_rt  in  5  source register B of the ID instruction.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_rw  in  5  destination after the RegDst mux.
- id_regwr  in  1  ID instruction writes the register file.
- id_memtoreg  in  1  ID instruction is a load.
- ex_br_taken  in  1  branch in EX resolved taken (valid only when EX holds a branch).
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_flush  out  1  load a bubble into ID/EX.
- fwd_a  out  2  EX operand A select: 00 = ID/EX busA, 01 = EX/MEM ALUout, 10 = WB busW.
- fwd_b  out  2  EX operand B select, same encoding as fwd_a.
- id_byp_a  out  1  ID busA takes busW instead of the register file.
- id_byp_b  out  1  ID busB takes busW instead of the register file.
- stall_cnt  out  CNT_W  cycles in which stall was asserted.
- flush_cnt  out  CNT_W  taken branches flushed.

Behaviour:
- Scoreboard holds three entries, EX, MEM and WB, each {v, rw, regwr, ld}.
- Every cycle the scoreboard shifts: WB<=MEM, MEM<=EX.
- EX loads {id_valid, id_rw, id_regwr, id_memtoreg} unless stall, flush or !id_valid; in those cases EX loads v=0.
- Entry "writes r" = v & regwr & rw==r & r!=0. Register 0 never matches anything.
- srcA hazard term = id_valid & id_use_rs; srcB uses id_use_rt / id_rt in the same way.
- Stall, EN_FWD=1: load-use only. Asserted when the EX entry has ld=1 and writes a used source.
- Stall, EN_FWD=0: asserted when any of the EX, MEM or WB entries writes a used source.
- Stall effects: pc_en=0, ifid_en=0, idex_flush=1. The scoreboard keeps shifting.
- Flush: ex_br_taken=1 gives ifid_flush=1 and idex_flush=1. pc_en=1 and ifid_en=1 so the PC takes the branch target.
- Flush has priority over stall. While flushing, stall is forced to 0 and is not counted.
- pc_en, ifid_en, ifid_flush, idex_flush and id_byp_* are combinational from the inputs and current state.
- fwd_a / fwd_b are registered and valid while the instruction is in EX.
- Next-value rule for fwd_a, when no stall/flush: 01 if the current EX entry writes id_rs; else 10 if the current MEM entry writes id_rs; else 00. fwd_b uses id_rt the same way.
- If the ID instruction becomes a bubble, fwd_* next = 00.
- If EN_FWD=0, fwd_* are always 00.
- id_byp_a = EN_FWD & WB entry writes id_rs & id_use_rs. This covers the write-and-read on the same edge, because the register file has no internal bypass. id_byp_b uses id_rt the same way.
- Load-use resolution: after a 1-cycle stall the load is in MEM. When the consumer enters EX the load is in WB, giving fwd=10.
- Counters increment by 1 per qualifying cycle and saturate at all-ones; they do not wrap.
- Reset state: scoreboard v=0, fwd_*=00, counters 0.
- Outputs while rst=1: pc_en=1, ifid_en=1, ifid_flush=0, idex_flush=0, id_byp_*=0.
- Reset asserted mid-stall or mid-flush: all in-flight entries are discarded next cycle and no stall persists.

Test Plan:
- Chain forward: add $3=$1+$2, then sub $4=$3,$5 back-to-back -> no stall; fwd_a=01 while sub is in EX; stall_cnt stays 0.
- Distance 2: add $3, nop, or $6=$3,$3 -> fwd_a=10 and fwd_b=10 while or is in EX.
- Load-use: lw $8, then add $9=$8,$1 -> exactly 1 cycle with pc_en=0, ifid_en=0, idex_flush=1; then fwd_a=10 for add; stall_cnt=1.
- Distance 3: lw $8, nop, nop, add $9=$8,$8 -> id_byp_a=1 and id_byp_b=1 in add's ID cycle; fwd=00.
- Taken branch: ex_br_taken=1 in the same cycle as a load-use condition -> ifid_flush=1, idex_flush=1, pc_en=1; stall_cnt unchanged, flush_cnt +1. Writes to $0 never forward or stall.
- EN_FWD=0 with CNT_W=2: add $3, then sub using $3 -> 3 stall cycles, fwd=00 throughout. Repeat the pair twice -> stall_cnt saturates at 3. Assert rst mid-stall -> stall drops the next cycle and counters read 0.
